multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Control FSM for the multicycle RV32I core, in which one ALU and one unified instruction/data memory port are shared across instruction phases. It sequences fetch, decode, address generation, memory access, execute and write-back. It drives every mux select and write enable in the datapath, and stalls on a memory ready handshake. Branch resolution (BEQ/BNE/BLT) and the ALU operation encoding match the single-cycle core, so the ALU and immediate generator are reused unchanged.

## Interface
- No parameters.
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- OP  in  7  opcode from instruction register
- funct3  in  3  instruction bits [14:12]
- funct7  in  1  instruction bit 30
- Zero  in  1  ALU zero flag
- sign  in  1  ALU sign flag (rs1 − rs2 negative)
- mem_ready  in  1  memory completes current access this cycle
- MemReq  out  1  memory access request (read or write)
- MemWrite  out  1  write qualifier for MemReq
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- IRWrite  out  1  load instruction register and OldPC
- PCWrite  out  1  load PC from result bus
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 = ALUOut, 01 = memory data reg, 10 = ALU result
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 reg
- ALUSrcB  out  2  00 = rs2 reg, 01 = immediate, 10 = constant 4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  3  000 add, 010 sub, 001 sll, 100 xor, 101 srl, 110 or, 111 and
- illegal  out  1  sticky unsupported-opcode flag
- state_o  out  4  current state encoding, for debug

## Operation
- The FSM is Moore for selects. PCWrite in BRANCH and the strobes in FETCH/MEMRD/MEMWR are also qualified by inputs.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - Holds while mem_ready=0.
  - When mem_ready=1: IRWrite=1 and PCWrite=1 (PC+4), then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, add. This computes the branch target into ALUOut. Next state by OP:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - anything else → ILLEGAL
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. ImmSrc=00 for loads, 01 for stores. Next state MEMRD (load) or MEMWR (store).
- MEMRD: MemReq=1, AdrSrc=1. Holds until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWR: MemReq=1, MemWrite=1, AdrSrc=1. Holds until mem_ready, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, then ALUWB.
- ALUControl in EXECR/EXECI, by funct3:
  - 000 → add. Exception: sub when OP[5]=1 and funct7=1.
  - 001 → sll
  - 100 → xor
  - 101 → srl
  - 110 → or
  - 111 → and
  - 010/011 → add (unsupported, no trap)
- ALUControl in all other states is add, except BRANCH (sub).
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, then FETCH.
  - PCWrite = Zero for funct3 000 (BEQ).
  - PCWrite = ~Zero for funct3 001 (BNE).
  - PCWrite = sign for funct3 100 (BLT).
  - PCWrite = 0 for any other funct3.
- ILLEGAL: all enables 0, illegal=1. Terminal until rst.

## Timing
- Cycles per instruction with mem_ready=1 on first request:
  - branch: 3
  - R-type, I-type, store: 4
  - load: 5
- Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds exactly one cycle. Outputs are held stable while waiting.
- mem_ready is ignored outside FETCH/MEMRD/MEMWR.
- Reset values:
  - While rst=1: state=FETCH, illegal=0. MemReq, MemWrite, IRWrite, PCWrite and RegWrite are forced 0; selects take their FETCH values.
  - First MemReq is in the first cycle after rst deasserts.
- rst asserted mid-instruction (including during a wait) aborts immediately. No write enable is asserted in the reset cycle.
- At most one of IRWrite/RegWrite/MemWrite is high in any cycle. PCWrite is high only in FETCH(ready), BRANCH(taken) and JAL.

## Configuration
- MCTRL_JAL_EN defined:
  - OP 1101111 in DECODE goes to JAL, with ImmSrc=11 in DECODE for this opcode.
  - JAL state: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 (target computed in DECODE), then ALUWB.
  - ALUWB writes rd = OldPC+4. JAL takes 4 cycles.
- MCTRL_JAL_EN undefined: OP 1101111 goes to ILLEGAL; ImmSrc=11 is never driven.

## Test plan
- Reset release, R-type add (OP 0110011, f3 000, f7 0), mem_ready=1 → FETCH, DECODE, EXECR, ALUWB.
  - RegWrite=1 only in cycle 4; ALUControl=000.
  - Repeat with f7=1 → ALUControl=010.
- Load with mem_ready low 2 cycles in FETCH and 3 in MEMRD → total 10 cycles.
  - MemReq, AdrSrc held stable during waits.
  - RegWrite with ResultSrc=01 once.
- Branches in BRANCH state:
  - BEQ Zero=1 → PCWrite=1.
  - BNE Zero=1 → PCWrite=0.
  - BLT sign=1 → PCWrite=1.
  - f3=010 with Zero=1 → PCWrite=0.
  - Each branch returns to FETCH after 3 cycles.
- Store → MEMWR with MemReq=MemWrite=AdrSrc=1; RegWrite never asserted.
- OP 1111111 → ILLEGAL, illegal=1 and no enables for 20 cycles; rst clears it and refetches.
- rst pulsed in MEMWR while mem_ready=0 → MemWrite drops immediately; state_o=FETCH.
- With MCTRL_JAL_EN: OP 1101111 → PCWrite in JAL, RegWrite ResultSrc=00 in ALUWB.
- Without MCTRL_JAL_EN: OP 1101111 → illegal=1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I core: sequences fetch/decode/address/memory/execute/write-back
// over a shared ALU and memory port. Define MCTRL_JAL_EN to add JAL support.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] OP,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    input  logic       sign,
    input  logic       mem_ready,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state_o
);

    // Memory handshake: a request (MemReq, with MemWrite qualifying stores) is held with all
    // selects stable until mem_ready is seen high; the access completes in that cycle.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_JAL     = 4'd10,
        S_ILLEGAL = 4'd11
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    state_t state, next;
    logic   mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;
    logic [2:0] exec_alu;
    logic       br_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= next;
    end

    always_comb begin
        exec_alu = ALU_ADD;
        case (funct3)
            3'b000:  exec_alu = (OP[5] && funct7) ? ALU_SUB : ALU_ADD;
            3'b001:  exec_alu = ALU_SLL;
            3'b100:  exec_alu = ALU_XOR;
            3'b101:  exec_alu = ALU_SRL;
            3'b110:  exec_alu = ALU_OR;
            3'b111:  exec_alu = ALU_AND;
            default: exec_alu = ALU_ADD;
        endcase
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = Zero;
            3'b001:  br_taken = ~Zero;
            3'b100:  br_taken = sign;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        next        = state;
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ImmSrc      = 2'b00;
        ALUControl  = ALU_ADD;
        case (state)
            S_FETCH: begin
                mem_req_c = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    next       = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target (OldPC + B-imm) is parked in ALUOut for BRANCH to use.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b10;
                case (OP)
                    7'b0000011, 7'b0100011: next = S_MEMADR;
                    7'b0110011:             next = S_EXECR;
                    7'b0010011:             next = S_EXECI;
                    7'b1100011:             next = S_BRANCH;
`ifdef MCTRL_JAL_EN
                    7'b1101111: begin
                        ImmSrc = 2'b11;
                        next   = S_JAL;
                    end
`endif
                    default:                next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = OP[5] ? 2'b01 : 2'b00;
                next    = OP[5] ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req_c = 1'b1;
                AdrSrc    = 1'b1;
                if (mem_ready) next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_c = 1'b1;
                next        = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                AdrSrc      = 1'b1;
                if (mem_ready) next = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = exec_alu;
                next       = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = exec_alu;
                next       = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                next        = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                pc_write_c = br_taken;
                next       = S_FETCH;
            end
`ifdef MCTRL_JAL_EN
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd.
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_write_c = 1'b1;
                next       = S_ALUWB;
            end
`endif
            S_ILLEGAL: next = S_ILLEGAL;
            default:   next = S_ILLEGAL;
        endcase
    end

    // Strobes are masked while rst is high so the reset cycle never requests or writes.
    assign MemReq   = mem_req_c   & ~rst;
    assign MemWrite = mem_write_c & ~rst;
    assign IRWrite  = ir_write_c  & ~rst;
    assign PCWrite  = pc_write_c  & ~rst;
    assign RegWrite = reg_write_c & ~rst;
    assign illegal  = (state == S_ILLEGAL);
    assign state_o  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected traces built from instruction class,
// a table of per-instruction totals, hand-written reset/wait/illegal sequences and random programs.
module tb_multicycle_ctrl;

    localparam logic [3:0] F = 4'd0, DEC = 4'd1, MADR = 4'd2, MRD = 4'd3, MWB = 4'd4, MWR = 4'd5,
                           EXR = 4'd6, EXI = 4'd7, AWB = 4'd8, BR = 4'd9, JL = 4'd10, ILL = 4'd11;
    localparam logic [6:0] OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_B = 7'b1100011, OP_JAL = 7'b1101111;
`ifdef MCTRL_JAL_EN
    localparam bit jal_en = 1'b1;
`else
    localparam bit jal_en = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b1;
    logic [6:0] OP = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7 = 1'b0, Zero = 1'b0, sign = 1'b0, mem_ready = 1'b0;
    logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .OP(OP), .funct3(funct3), .funct7(funct7), .Zero(Zero),
        .sign(sign), .mem_ready(mem_ready), .MemReq(MemReq), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // One expected cycle: mem_ready to drive, plus outputs. care = {adr,res,sa,sb,imm}.
    typedef struct {
        logic       mr;
        logic [3:0] st;
        logic       req, wr, irw, pcw, rgw, adr, ill;
        logic [1:0] res, sa, sb, imm;
        logic [2:0] alu;
        logic [4:0] care;
    } rec_t;

    rec_t exp_q[$];

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, z, s;
        int         cycles, rw, pw;
    } vec_t;

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic op5, input logic f7);
        case (f3)
            3'b000:  return (op5 && f7) ? 3'b010 : 3'b000;
            3'b001:  return 3'b001;
            3'b100:  return 3'b100;
            3'b101:  return 3'b101;
            3'b110:  return 3'b110;
            3'b111:  return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic taken(input logic [2:0] f3, input logic z, input logic s);
        return (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : (f3 == 3'b100) ? s : 1'b0;
    endfunction

    function automatic rec_t base(input logic [3:0] st);
        rec_t r;
        r.mr = 1'($urandom_range(0, 1));
        r.st = st; r.req = 0; r.wr = 0; r.irw = 0; r.pcw = 0; r.rgw = 0; r.adr = 0; r.ill = 0;
        r.res = 0; r.sa = 0; r.sb = 0; r.imm = 0; r.alu = 3'b000; r.care = 5'b00000;
        return r;
    endfunction

    function automatic rec_t fetch_rec(input logic ready);
        rec_t r = base(F);
        r.mr = ready; r.req = 1; r.sb = 2'b10; r.res = 2'b10; r.irw = ready; r.pcw = ready;
        r.care = 5'b11110;
        return r;
    endfunction

    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input logic s, input int wf, input int wm);
        rec_t r;
        for (int i = 0; i < wf; i++) exp_q.push_back(fetch_rec(1'b0));
        exp_q.push_back(fetch_rec(1'b1));
        r = base(DEC); r.sa = 1; r.sb = 1; r.imm = (jal_en && op == OP_JAL) ? 2'b11 : 2'b10;
        r.care = 5'b00111; exp_q.push_back(r);
        if (op == OP_LD || op == OP_ST) begin
            r = base(MADR); r.sa = 2; r.sb = 1; r.imm = (op == OP_ST) ? 2'b01 : 2'b00;
            r.care = 5'b00111; exp_q.push_back(r);
            for (int i = 0; i <= wm; i++) begin
                r = base((op == OP_ST) ? MWR : MRD);
                r.mr = (i == wm); r.req = 1; r.adr = 1; r.wr = (op == OP_ST); r.care = 5'b10000;
                exp_q.push_back(r);
            end
            if (op == OP_LD) begin
                r = base(MWB); r.res = 2'b01; r.rgw = 1; r.care = 5'b01000; exp_q.push_back(r);
            end
        end else if (op == OP_R || op == OP_I) begin
            r = base((op == OP_R) ? EXR : EXI); r.sa = 2; r.sb = (op == OP_I) ? 2'b01 : 2'b00;
            r.alu = alu_of(f3, op[5], f7); r.care = (op == OP_I) ? 5'b00111 : 5'b00110;
            exp_q.push_back(r);
            r = base(AWB); r.rgw = 1; r.care = 5'b01000; exp_q.push_back(r);
        end else if (op == OP_B) begin
            r = base(BR); r.sa = 2; r.alu = 3'b010; r.pcw = taken(f3, z, s); r.care = 5'b01110;
            exp_q.push_back(r);
        end else if (jal_en && op == OP_JAL) begin
            r = base(JL); r.sa = 1; r.sb = 2; r.pcw = 1; r.care = 5'b01110; exp_q.push_back(r);
            r = base(AWB); r.rgw = 1; r.care = 5'b01000; exp_q.push_back(r);
        end else begin
            for (int i = 0; i < 20; i++) begin
                r = base(ILL); r.ill = 1; exp_q.push_back(r);
            end
        end
    endtask

    task automatic check_rec(input string name, input int idx, input rec_t r);
        bit ok;
        ok = (state_o === r.st) && (illegal === r.ill) && (ALUControl === r.alu) &&
             ({MemReq, MemWrite, IRWrite, PCWrite, RegWrite} === {r.req, r.wr, r.irw, r.pcw, r.rgw}) &&
             (!r.care[4] || AdrSrc === r.adr) && (!r.care[3] || ResultSrc === r.res) &&
             (!r.care[2] || ALUSrcA === r.sa) && (!r.care[1] || ALUSrcB === r.sb) &&
             (!r.care[0] || ImmSrc === r.imm);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s cyc%0d: got st=%0d req/wr/ir/pc/rw=%b adr=%b res=%b a=%b b=%b imm=%b alu=%b ill=%b; want st=%0d %b adr=%b res=%b a=%b b=%b imm=%b alu=%b ill=%b care=%b",
                     name, idx, state_o, {MemReq, MemWrite, IRWrite, PCWrite, RegWrite}, AdrSrc,
                     ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, r.st,
                     {r.req, r.wr, r.irw, r.pcw, r.rgw}, r.adr, r.res, r.sa, r.sb, r.imm, r.alu,
                     r.ill, r.care);
        end
    endtask

    task automatic expect_eq(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Apply up to n records (n<0: whole queue). Counts DUT cycles until state_o is back at FETCH.
    task automatic run_q(input string name, input int n, output int cyc, output int rw,
                         output int pw, output bit back);
        rec_t r;
        bit left = 0;
        int idx = 0;
        cyc = 0; rw = 0; pw = 0; back = 0;
        while (exp_q.size() > 0 && (n < 0 || idx < n)) begin
            r = exp_q.pop_front();
            mem_ready = r.mr;
            #1;
            check_rec(name, idx, r);
            rw += int'(RegWrite);
            pw += int'(PCWrite);
            if (!back) begin
                if (state_o != F) left = 1;
                else if (left) back = 1;
                if (!back) cyc++;
            end
            idx++;
            @(negedge clk);
        end
        #1;
        if (left && state_o == F) back = 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input logic s);
        OP = op; funct3 = f3; funct7 = f7; Zero = z; sign = s;
    endtask

    vec_t vt[$];
    int   cyc, rw, pw;
    bit   back;
    rec_t rr;

    initial begin
        vt.push_back('{OP_R,  3'b000, 1'b0, 1'b0, 1'b0, 4, 1, 1});
        vt.push_back('{OP_R,  3'b000, 1'b1, 1'b0, 1'b0, 4, 1, 1});
        vt.push_back('{OP_I,  3'b000, 1'b1, 1'b0, 1'b0, 4, 1, 1});
        vt.push_back('{OP_R,  3'b111, 1'b0, 1'b0, 1'b0, 4, 1, 1});
        vt.push_back('{OP_ST, 3'b010, 1'b0, 1'b0, 1'b0, 4, 0, 1});
        vt.push_back('{OP_LD, 3'b010, 1'b0, 1'b0, 1'b0, 5, 1, 1});
        vt.push_back('{OP_B,  3'b000, 1'b0, 1'b1, 1'b0, 3, 0, 2});
        vt.push_back('{OP_B,  3'b001, 1'b0, 1'b1, 1'b0, 3, 0, 1});
        vt.push_back('{OP_B,  3'b100, 1'b0, 1'b0, 1'b1, 3, 0, 2});
        vt.push_back('{OP_B,  3'b010, 1'b0, 1'b1, 1'b0, 3, 0, 1});
        if (jal_en) vt.push_back('{OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 4, 1, 2});

        // Held in reset with mem_ready high: FETCH selects, no strobes, no illegal.
        mem_ready = 1'b1;
        rr = fetch_rec(1'b1);
        rr.req = 0; rr.irw = 0; rr.pcw = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check_rec("reset_hold", i, rr);
        end
        @(negedge clk);
        do_reset();

        // Table: per-instruction cycle count and DUT-observed write-enable totals.
        foreach (vt[i]) begin
            set_instr(vt[i].op, vt[i].f3, vt[i].f7, vt[i].z, vt[i].s);
            build(vt[i].op, vt[i].f3, vt[i].f7, vt[i].z, vt[i].s, 0, 0);
            run_q($sformatf("vec%0d", i), -1, cyc, rw, pw, back);
            expect_eq($sformatf("vec%0d_cycles", i), back ? cyc : -1, vt[i].cycles);
            expect_eq($sformatf("vec%0d_regwrites", i), rw, vt[i].rw);
            expect_eq($sformatf("vec%0d_pcwrites", i), pw, vt[i].pw);
        end

        // Load with 2 fetch waits and 3 memory waits: 10 cycles, one MEMWB write.
        set_instr(OP_LD, 3'b010, 1'b0, 1'b0, 1'b0);
        build(OP_LD, 3'b010, 1'b0, 1'b0, 1'b0, 2, 3);
        run_q("load_waits", -1, cyc, rw, pw, back);
        expect_eq("load_waits_cycles", back ? cyc : -1, 10);
        expect_eq("load_waits_regwrites", rw, 1);

        // Store with waits: never a register write.
        set_instr(OP_ST, 3'b010, 1'b0, 1'b0, 1'b0);
        build(OP_ST, 3'b010, 1'b0, 1'b0, 1'b0, 1, 2);
        run_q("store_waits", -1, cyc, rw, pw, back);
        expect_eq("store_waits_cycles", back ? cyc : -1, 7);
        expect_eq("store_waits_regwrites", rw, 0);

        // Random programs.
        for (int k = 0; k < 40; k++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic f7, z, s;
            case ($urandom_range(0, jal_en ? 5 : 4))
                0: op = OP_LD;
                1: op = OP_ST;
                2: op = OP_R;
                3: op = OP_I;
                4: op = OP_B;
                default: op = OP_JAL;
            endcase
            f3 = 3'($urandom_range(0, 7));
            f7 = 1'($urandom_range(0, 1));
            z  = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            set_instr(op, f3, f7, z, s);
            build(op, f3, f7, z, s, $urandom_range(0, 3), $urandom_range(0, 3));
            run_q($sformatf("rand%0d", k), -1, cyc, rw, pw, back);
        end

        // Unsupported opcode: terminal ILLEGAL for 20 cycles, reset clears and refetches.
        set_instr(7'b1111111, 3'b000, 1'b0, 1'b1, 1'b1);
        build(7'b1111111, 3'b000, 1'b0, 1'b1, 1'b1, 0, 0);
        run_q("illegal_op", -1, cyc, rw, pw, back);
        rst = 1'b1; #1;
        expect_eq("illegal_cleared_by_rst", int'(illegal), 0);
        expect_eq("illegal_rst_state", int'(state_o), int'(F));
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0; #1;
        expect_eq("refetch_memreq", int'(MemReq), 1);
        @(negedge clk);
        set_instr(OP_R, 3'b100, 1'b0, 1'b0, 1'b0);
        build(OP_R, 3'b100, 1'b0, 1'b0, 1'b0, 0, 0);
        run_q("after_illegal", -1, cyc, rw, pw, back);

        // JAL opcode: supported only with the feature macro.
        set_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0);
        build(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 0, 1);
        run_q("jal_op", -1, cyc, rw, pw, back);
        expect_eq("jal_illegal_flag", int'(illegal), jal_en ? 0 : 1);
        if (!jal_en) do_reset();

        // Reset pulsed in MEMWR while waiting: write drops at once, state returns to FETCH.
        set_instr(OP_ST, 3'b010, 1'b0, 1'b0, 1'b0);
        build(OP_ST, 3'b010, 1'b0, 1'b0, 1'b0, 0, 6);
        run_q("store_abort", 5, cyc, rw, pw, back);
        exp_q.delete();
        mem_ready = 1'b0; #1;
        expect_eq("memwr_before_rst", int'(MemWrite), 1);
        rst = 1'b1; #1;
        expect_eq("memwr_dropped", int'(MemWrite), 0);
        expect_eq("memreq_dropped", int'(MemReq), 0);
        expect_eq("abort_state_fetch", int'(state_o), int'(F));
        @(negedge clk);
        rst = 1'b0; #1;
        expect_eq("abort_refetch_memreq", int'(MemReq), 1);
        @(negedge clk);
        set_instr(OP_I, 3'b110, 1'b0, 1'b0, 1'b0);
        build(OP_I, 3'b110, 1'b0, 1'b0, 1'b0, 1, 0);
        run_q("after_abort", -1, cyc, rw, pw, back);
        expect_eq("after_abort_cycles", back ? cyc : -1, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
